// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA), the arbiter and the memory model.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
);
  // Requester side
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;

  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata, mem_addr, mem_wdata, mem_re, mem_we
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata, mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the single-port 2K x 16 memory (CPU = 0, DMA = 1).
// Holds mem_re/mem_we for MEM_LAT cycles per access, then pulses done for one cycle.
// Optional feature: define ARB_FIXED_PRIO_EN to make the CPU win every tie
// (default build is round-robin on ties).
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 5   // legal range 1..15
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              owner_q, owner_d;  // last_owner; also selects which gnt/done is driven
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic any_req;
  logic winner;

  // Pick the requester to serve when leaving IDLE
  always_comb begin
    any_req = bus.req0 | bus.req1;
`ifdef ARB_FIXED_PRIO_EN
    winner = ~bus.req0;
`else
    if (bus.req0 && bus.req1) begin
      winner = ~owner_q;
    end else begin
      winner = ~bus.req0;
    end
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      owner_q <= 1'b1;  // CPU wins the first tie
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StAccess;
          owner_d = winner;
          cnt_d   = CntW'(MEM_LAT - 1);
          we_d    = winner ? bus.we1    : bus.we0;
          addr_d  = winner ? bus.addr1  : bus.addr0;
          wdata_d = winner ? bus.wdata1 : bus.wdata0;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          // Read data is valid on the last cycle of the strobe window
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs decoded from state and the latched owner/direction
  always_comb begin
    bus.gnt0      = (state_q != StIdle) && !owner_q;
    bus.gnt1      = (state_q != StIdle) &&  owner_q;
    bus.done0     = (state_q == StDone) && !owner_q;
    bus.done1     = (state_q == StDone) &&  owner_q;
    bus.mem_re    = (state_q == StAccess) && !we_q;
    bus.mem_we    = (state_q == StAccess) &&  we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.rdata     = rdata_q;
  end

endmodule
